// File: rtl/button_conditioner.sv
// Four-channel button conditioner: 2-flop synchronizer, counter debounce,
// rising-level press strobe and a sticky pending flag cleared by acknowledge.
module button_conditioner #(
    parameter int unsigned DB_LIMIT = 250000,
    parameter int unsigned CNT_W    = 18
) (
    input  logic       clk0,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_level,
    output logic [3:0] btn_pulse,
    output logic [3:0] btn_pend,
    input  logic [3:0] btn_ack
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_LIMIT - 1);

    logic [3:0]       s1_q, s2_q;
    logic [3:0]       level_q, level_d;
    logic [3:0]       pulse_q, pulse_d;
    logic [3:0]       pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    always_comb begin
        level_d = level_q;
        pulse_d = '0;
        pend_d  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = s2_q[i];
                    // Strobe only on a rising debounced level; release is silent.
                    pulse_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            // A new press beats a coincident acknowledge.
            pend_d[i] = pulse_d[i] | (pend_q[i] & ~btn_ack[i]);
        end
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            pulse_q <= '0;
            pend_q  <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= btn_raw;
            s2_q    <= s1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;
    assign btn_pend  = pend_q;

endmodule
